// File: rtl/exponent_pkg.sv
// Shared types and constants for the exponent accelerator host.
// Holds the host FSM state encoding and operand/counter widths.
package exponent_pkg;

    localparam int OPERAND_W = 32;
    // Wide enough for the largest legal completion timeout (65535).
    localparam int COUNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_RESPOND
    } host_state_t;

    function automatic logic is_waiting(input host_state_t state);
        return (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/operand_hold_register.sv
// Loadable hold register with synchronous active-high reset.
// Captures a request field and keeps it until the next load.
module operand_hold_register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exponent_host.sv
// Request/response host for a single-operation exponent accelerator.
// Launches one operation per request, waits for completion or timeout.
module exponent_host
    import exponent_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OPERAND_W-1:0] req_x,
    input  logic [OPERAND_W-1:0] req_a,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 exp_enable,
    output logic [OPERAND_W-1:0] exp_x,
    output logic [OPERAND_W-1:0] exp_a,
    input  logic                 exp_ready,
    input  logic [OPERAND_W-1:0] exp_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OPERAND_W-1:0] rsp_p,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_timeout,
    output logic                 busy
);

    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(TIMEOUT - 1);

    host_state_t          state_reg, state_next;
    logic [COUNT_W-1:0]   counter_reg, counter_next;
    logic                 exp_enable_reg, exp_enable_next;
    logic [OPERAND_W-1:0] rsp_p_reg, rsp_p_next;
    logic                 rsp_timeout_reg, rsp_timeout_next;
    logic                 accept;
    logic                 timed_out;

    assign accept    = req_valid && (state_reg == ST_IDLE);
    assign timed_out = is_waiting(state_reg) && (counter_reg == COUNT_LAST);

    // Operands drive the accelerator directly, so they only move on acceptance.
    operand_hold_register #(.WIDTH(OPERAND_W)) u_hold_x (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .d     (req_x),
        .q     (exp_x)
    );

    operand_hold_register #(.WIDTH(OPERAND_W)) u_hold_a (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .d     (req_a),
        .q     (exp_a)
    );

    operand_hold_register #(.WIDTH(TAG_W)) u_hold_tag (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .d     (req_tag),
        .q     (rsp_tag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            counter_reg     <= '0;
            exp_enable_reg  <= 1'b0;
            rsp_p_reg       <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            exp_enable_reg  <= exp_enable_next;
            rsp_p_reg       <= rsp_p_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        counter_next     = '0;
        exp_enable_next  = 1'b0;
        rsp_p_next       = rsp_p_reg;
        rsp_timeout_next = rsp_timeout_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    // x^0 is 1 for every x, so the accelerator is bypassed.
                    if (req_a == '0) begin
                        state_next       = ST_RESPOND;
                        rsp_p_next       = OPERAND_W'(1);
                        rsp_timeout_next = 1'b0;
                    end else begin
                        state_next = ST_LAUNCH;
                    end
                end
            end

            ST_LAUNCH: begin
                if (exp_ready) begin
                    exp_enable_next = 1'b1;
                    state_next      = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                counter_next = counter_reg + COUNT_W'(1);
                if (timed_out) begin
                    state_next       = ST_RESPOND;
                    rsp_p_next       = '0;
                    rsp_timeout_next = 1'b1;
                end else if (!exp_ready) begin
                    state_next = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                counter_next = counter_reg + COUNT_W'(1);
                // A completion arriving on the final counted cycle still counts.
                if (exp_ready) begin
                    state_next       = ST_RESPOND;
                    rsp_p_next       = exp_p;
                    rsp_timeout_next = 1'b0;
                end else if (timed_out) begin
                    state_next       = ST_RESPOND;
                    rsp_p_next       = '0;
                    rsp_timeout_next = 1'b1;
                end
            end

            ST_RESPOND: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign req_ready   = (state_reg == ST_IDLE);
    assign busy        = (state_reg != ST_IDLE);
    assign rsp_valid   = (state_reg == ST_RESPOND);
    assign exp_enable  = exp_enable_reg;
    assign rsp_p       = rsp_p_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_exponent_host.sv
// Directed testbench for exponent_host with a cycle-stepped accelerator model.
// Expected results are hand-computed constants per scenario.
module tb_exponent_host;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_x;
    logic [31:0] req_a;
    logic [3:0]  req_tag;
    logic        exp_enable;
    logic [31:0] exp_x;
    logic [31:0] exp_a;
    logic        exp_ready;
    logic [31:0] exp_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_p;
    logic [3:0]  rsp_tag;
    logic        rsp_timeout;
    logic        busy;

    int compared;
    int mismatched;

    // Accelerator model state
    bit          acc_busy;
    int          acc_cnt;
    int          busy_cycles;
    bit          never_done;
    int          force_low;
    int          enable_count;
    logic [31:0] acc_result;

    exponent_host #(.TAG_W(4), .TIMEOUT(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_a       (req_a),
        .req_tag     (req_tag),
        .exp_enable  (exp_enable),
        .exp_x       (exp_x),
        .exp_a       (exp_a),
        .exp_ready   (exp_ready),
        .exp_p       (exp_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_p       (rsp_p),
        .rsp_tag     (rsp_tag),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] pow32(input logic [31:0] x, input logic [31:0] a);
        logic [31:0] r;
        logic [31:0] b;
        r = 32'd1;
        b = x;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) r = r * b;
            b = b * b;
        end
        return r;
    endfunction

    // One clock: advance to 1 time unit after the edge, then step the accelerator.
    task automatic tick();
        logic en_sample;
        en_sample = exp_enable;
        @(posedge clock);
        #1;
        if (en_sample) enable_count++;
        if (reset) begin
            acc_busy  = 1'b0;
            exp_ready = 1'b1;
            force_low = 0;
        end else if (acc_busy) begin
            acc_cnt++;
            if (!never_done && acc_cnt >= busy_cycles) begin
                exp_ready = 1'b1;
                exp_p     = acc_result;
                acc_busy  = 1'b0;
            end
        end else if (en_sample) begin
            acc_busy   = 1'b1;
            acc_cnt    = 0;
            exp_ready  = 1'b0;
            exp_p      = 32'hDEAD_BEEF;
            acc_result = pow32(exp_x, exp_a);
        end else if (force_low > 0) begin
            force_low--;
            if (force_low == 0) exp_ready = 1'b1;
        end
        $display("t=%0t req_v=%0b req_r=%0b en=%0b exp_r=%0b rsp_v=%0b rsp_p=%0d tag=%0d to=%0b busy=%0b",
                 $time, req_valid, req_ready, exp_enable, exp_ready, rsp_valid, rsp_p, rsp_tag, rsp_timeout, busy);
    endtask

    task automatic issue_request(input logic [31:0] x, input logic [31:0] a, input logic [3:0] tag);
        req_valid = 1'b1;
        req_x     = x;
        req_a     = a;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        compared++; if (exp_enable !== 1'b0) begin mismatched++; $display("FAIL reset_exp_enable: got %0b expected 0", exp_enable); end
        compared++; if (rsp_p !== 32'd0) begin mismatched++; $display("FAIL reset_rsp_p: got %0d expected 0", rsp_p); end
        compared++; if (rsp_tag !== 4'd0) begin mismatched++; $display("FAIL reset_rsp_tag: got %0d expected 0", rsp_tag); end
        compared++; if (rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_timeout: got %0b expected 0", rsp_timeout); end
        compared++; if (exp_x !== 32'd0 || exp_a !== 32'd0) begin mismatched++; $display("FAIL reset_operands: got x=%0d a=%0d expected 0/0", exp_x, exp_a); end
        reset = 1'b0;
        tick();
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
    endtask

    task automatic test_basic();
        int n;
        busy_cycles  = 2;
        enable_count = 0;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL basic_ready_before: got %0b expected 1", req_ready); end
        issue_request(32'd3, 32'd4, 4'd5);
        compared++; if (exp_x !== 32'd3 || exp_a !== 32'd4) begin mismatched++; $display("FAIL basic_operands: got x=%0d a=%0d expected 3/4", exp_x, exp_a); end
        compared++; if (busy !== 1'b1 || req_ready !== 1'b0) begin mismatched++; $display("FAIL basic_busy: got busy=%0b ready=%0b expected 1/0", busy, req_ready); end
        wait_rsp(40, n);
        compared++; if (n != 5) begin mismatched++; $display("FAIL basic_latency: got %0d expected 5", n); end
        compared++; if (rsp_p !== 32'd81) begin mismatched++; $display("FAIL basic_rsp_p: got %0d expected 81", rsp_p); end
        compared++; if (rsp_tag !== 4'd5) begin mismatched++; $display("FAIL basic_rsp_tag: got %0d expected 5", rsp_tag); end
        compared++; if (rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL basic_rsp_timeout: got %0b expected 0", rsp_timeout); end
        compared++; if (enable_count != 1) begin mismatched++; $display("FAIL basic_enable_pulses: got %0d expected 1", enable_count); end
        handshake();
        compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin mismatched++; $display("FAIL basic_after_hs: got valid=%0b ready=%0b expected 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_min_latency();
        int n;
        busy_cycles = 1;
        issue_request(32'd6, 32'd2, 4'd1);
        wait_rsp(40, n);
        compared++; if (n != 4) begin mismatched++; $display("FAIL minlat_latency: got %0d expected 4", n); end
        compared++; if (rsp_p !== 32'd36) begin mismatched++; $display("FAIL minlat_rsp_p: got %0d expected 36", rsp_p); end
        handshake();
    endtask

    task automatic test_bypass();
        enable_count = 0;
        issue_request(32'd7, 32'd0, 4'd9);
        compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL bypass_rsp_valid: got %0b expected 1", rsp_valid); end
        compared++; if (rsp_p !== 32'd1) begin mismatched++; $display("FAIL bypass_rsp_p: got %0d expected 1", rsp_p); end
        compared++; if (rsp_tag !== 4'd9 || rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL bypass_tag_to: got tag=%0d to=%0b expected 9/0", rsp_tag, rsp_timeout); end
        tick();
        tick();
        compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL bypass_hold: got %0b expected 1", rsp_valid); end
        compared++; if (enable_count != 0) begin mismatched++; $display("FAIL bypass_no_enable: got %0d expected 0", enable_count); end
        handshake();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bypass_idle: got busy=%0b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int n;
        never_done = 1'b1;
        issue_request(32'd2, 32'd10, 4'd3);
        wait_rsp(40, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL timeout_latency: got %0d expected 9", n); end
        compared++; if (rsp_p !== 32'd0) begin mismatched++; $display("FAIL timeout_rsp_p: got %0d expected 0", rsp_p); end
        compared++; if (rsp_timeout !== 1'b1) begin mismatched++; $display("FAIL timeout_flag: got %0b expected 1", rsp_timeout); end
        compared++; if (rsp_tag !== 4'd3) begin mismatched++; $display("FAIL timeout_rsp_tag: got %0d expected 3", rsp_tag); end
        handshake();
        compared++; if (req_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL timeout_to_idle: got ready=%0b busy=%0b expected 1/0", req_ready, busy); end
        never_done = 1'b0;
        acc_busy   = 1'b0;
        exp_ready  = 1'b1;
    endtask

    task automatic test_completion_race();
        int n;
        // Completion lands on the final counted cycle: completion must win.
        busy_cycles = 6;
        issue_request(32'd3, 32'd2, 4'd4);
        wait_rsp(40, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL race_win_latency: got %0d expected 9", n); end
        compared++; if (rsp_p !== 32'd9 || rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL race_win_result: got p=%0d to=%0b expected 9/0", rsp_p, rsp_timeout); end
        handshake();
        // One cycle later than that is a timeout.
        busy_cycles = 7;
        issue_request(32'd3, 32'd3, 4'd8);
        wait_rsp(40, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL race_late_latency: got %0d expected 9", n); end
        compared++; if (rsp_p !== 32'd0 || rsp_timeout !== 1'b1) begin mismatched++; $display("FAIL race_late_result: got p=%0d to=%0b expected 0/1", rsp_p, rsp_timeout); end
        handshake();
    endtask

    task automatic test_deferred_launch();
        int n;
        busy_cycles  = 1;
        exp_ready    = 1'b0;
        force_low    = 5;
        enable_count = 0;
        issue_request(32'd5, 32'd3, 4'd10);
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (exp_enable !== 1'b0) begin mismatched++; $display("FAIL deferred_no_enable[%0d]: got %0b expected 0", i, exp_enable); end
        end
        wait_rsp(40, n);
        compared++; if (n != 4) begin mismatched++; $display("FAIL deferred_latency: got %0d expected 4", n); end
        compared++; if (rsp_p !== 32'd125 || rsp_tag !== 4'd10) begin mismatched++; $display("FAIL deferred_result: got p=%0d tag=%0d expected 125/10", rsp_p, rsp_tag); end
        compared++; if (enable_count != 1) begin mismatched++; $display("FAIL deferred_pulses: got %0d expected 1", enable_count); end
        handshake();
    endtask

    task automatic test_rsp_stall();
        int n;
        busy_cycles = 1;
        issue_request(32'd2, 32'd5, 4'd6);
        wait_rsp(40, n);
        compared++; if (rsp_p !== 32'd32) begin mismatched++; $display("FAIL stall_rsp_p: got %0d expected 32", rsp_p); end
        req_valid = 1'b1;
        req_x     = 32'd9;
        req_a     = 32'd9;
        req_tag   = 4'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            compared++; if (rsp_valid !== 1'b1 || rsp_p !== 32'd32 || rsp_tag !== 4'd6) begin mismatched++; $display("FAIL stall_hold[%0d]: got v=%0b p=%0d tag=%0d expected 1/32/6", i, rsp_valid, rsp_p, rsp_tag); end
            compared++; if (req_ready !== 1'b0 || exp_x !== 32'd2) begin mismatched++; $display("FAIL stall_blocked[%0d]: got ready=%0b x=%0d expected 0/2", i, req_ready, exp_x); end
        end
        req_valid = 1'b0;
        handshake();
        compared++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL stall_release: got ready=%0b valid=%0b expected 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        busy_cycles = 1;
        issue_request(32'd7, 32'd0, 4'd1);
        req_valid = 1'b1;
        req_x     = 32'd4;
        req_a     = 32'd2;
        req_tag   = 4'd2;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        compared++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || exp_x !== 32'd7) begin mismatched++; $display("FAIL b2b_idle_gap: got v=%0b ready=%0b x=%0d expected 0/1/7", rsp_valid, req_ready, exp_x); end
        tick();
        req_valid = 1'b0;
        compared++; if (busy !== 1'b1 || exp_x !== 32'd4 || exp_a !== 32'd2) begin mismatched++; $display("FAIL b2b_accept: got busy=%0b x=%0d a=%0d expected 1/4/2", busy, exp_x, exp_a); end
        wait_rsp(40, n);
        compared++; if (n != 4 || rsp_p !== 32'd16 || rsp_tag !== 4'd2) begin mismatched++; $display("FAIL b2b_result: got n=%0d p=%0d tag=%0d expected 4/16/2", n, rsp_p, rsp_tag); end
        handshake();
    endtask

    task automatic test_reset_mid();
        bit seen;
        busy_cycles = 3;
        issue_request(32'd3, 32'd3, 4'd7);
        tick();
        tick();
        tick();
        compared++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_in_wait: got busy=%0b v=%0b expected 1/0", busy, rsp_valid); end
        reset = 1'b1;
        tick();
        compared++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || exp_enable !== 1'b0) begin mismatched++; $display("FAIL midrst_ctrl: got busy=%0b v=%0b en=%0b expected 0/0/0", busy, rsp_valid, exp_enable); end
        compared++; if (rsp_p !== 32'd0 || rsp_tag !== 4'd0 || rsp_timeout !== 1'b0) begin mismatched++; $display("FAIL midrst_rsp: got p=%0d tag=%0d to=%0b expected 0/0/0", rsp_p, rsp_tag, rsp_timeout); end
        compared++; if (exp_x !== 32'd0 || exp_a !== 32'd0) begin mismatched++; $display("FAIL midrst_operands: got x=%0d a=%0d expected 0/0", exp_x, exp_a); end
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL midrst_no_response: got %0b expected 0", seen); end
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %0b expected 1", req_ready); end
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_x        = '0;
        req_a        = '0;
        req_tag      = '0;
        rsp_ready    = 1'b0;
        exp_ready    = 1'b1;
        exp_p        = '0;
        acc_busy     = 1'b0;
        acc_cnt      = 0;
        busy_cycles  = 1;
        never_done   = 1'b0;
        force_low    = 0;
        enable_count = 0;
        acc_result   = '0;

        test_reset();
        test_basic();
        test_min_latency();
        test_bypass();
        test_timeout();
        test_completion_race();
        test_deferred_launch();
        test_rsp_stall();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
